// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/cs_n/mosi on clk, deserialises frames onto
// rx_data/rx_valid and serialises a one-word transmit buffer (or DEFAULT_TX) onto miso.
module spi_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_error
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic sclk_m_reg, sclk_s_reg, sclk_d_reg;
  logic cs_m_reg, cs_s_reg, cs_d_reg;
  logic mosi_m_reg, mosi_s_reg;

  logic [DATA_WIDTH-1:0] tx_shift_reg;
  logic [DATA_WIDTH-1:0] rx_shift_reg;
  logic [DATA_WIDTH-1:0] buf_data_reg;
  logic                  buf_full_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  reload_reg;

  logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                  buf_write, load_evt;
  logic [DATA_WIDTH-1:0] load_word, rx_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_m_reg <= 1'b0;
      sclk_s_reg <= 1'b0;
      sclk_d_reg <= 1'b0;
      cs_m_reg   <= 1'b1;
      cs_s_reg   <= 1'b1;
      cs_d_reg   <= 1'b1;
      mosi_m_reg <= 1'b0;
      mosi_s_reg <= 1'b0;
    end else begin
      sclk_m_reg <= sclk;
      sclk_s_reg <= sclk_m_reg;
      sclk_d_reg <= sclk_s_reg;
      cs_m_reg   <= cs_n;
      cs_s_reg   <= cs_m_reg;
      cs_d_reg   <= cs_s_reg;
      mosi_m_reg <= mosi;
      mosi_s_reg <= mosi_m_reg;
    end
  end

  assign sclk_rise = sclk_s_reg & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s_reg & sclk_d_reg;
  assign cs_fall   = ~cs_s_reg & cs_d_reg;
  assign cs_rise   = cs_s_reg & ~cs_d_reg;

  assign busy      = ~cs_s_reg;
  assign miso_oe   = busy;
  assign miso      = busy & tx_shift_reg[DATA_WIDTH-1];
  assign tx_ready  = ~buf_full_reg;
  assign buf_write = tx_valid & ~buf_full_reg;
  assign rx_next   = {rx_shift_reg[DATA_WIDTH-2:0], mosi_s_reg};

  // Load decisions see the buffer as it was before any same-cycle write.
  assign load_word = buf_full_reg ? buf_data_reg : DEFAULT_TX;
  assign load_evt  = cs_fall | (busy & sclk_fall & reload_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      buf_data_reg <= '0;
      buf_full_reg <= 1'b0;
      cnt_reg      <= '0;
      reload_reg   <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;

      if (buf_write) begin
        buf_data_reg <= tx_data;
        buf_full_reg <= 1'b1;
      end else if (load_evt && buf_full_reg) begin
        buf_full_reg <= 1'b0;
      end

      if (cs_fall) begin
        tx_shift_reg <= load_word;
        cnt_reg      <= '0;
        reload_reg   <= 1'b0;
      end else if (cs_rise) begin
        if (cnt_reg != '0) frame_error <= 1'b1;
        cnt_reg    <= '0;
        reload_reg <= 1'b0;
      end else if (busy) begin
        if (sclk_rise) begin
          rx_shift_reg <= rx_next;
          if (cnt_reg == LAST_BIT) begin
            cnt_reg    <= '0;
            reload_reg <= 1'b1;
            rx_data    <= rx_next;
            rx_valid   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        // The fall after the last rise presents the next word's MSB for back-to-back frames.
        if (sclk_fall) begin
          if (reload_reg) begin
            tx_shift_reg <= load_word;
            reload_reg   <= 1'b0;
          end else begin
            tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
